lsu_sq_fwd: RTL and testbench

- Parametrised store queue for the out-of-order LSU, with store-to-load forwarding and an in-order committed-store drain to the data memory.
- Sits between dispatch/execute, the ROB commit path and the DM interface.
- Adds two things the previous LSU lacked: byte-accurate forwarding from older stores, and configurable depth and ROB index width.

---
 rtl/lsu_sq_fwd_if.sv | 55 +++++
 rtl/lsu_sq_fwd.sv | 160 ++++++++++++++++
 tb/tb_lsu_sq_fwd.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_sq_fwd_if.sv
// Store-queue port bundle: dispatch, execute, commit/flush, load query and DM drain.
interface lsu_sq_fwd_if #(
    parameter int SQ_DEPTH = 8,
    parameter int ROB_W    = 5
);
    localparam int PTR_W = $clog2(SQ_DEPTH) + 1;

    logic             alloc_valid;
    logic [ROB_W-1:0] alloc_rob_idx;
    logic             alloc_ready;
    logic [PTR_W-1:0] sq_tail;

    logic             ex_valid;
    logic [PTR_W-1:0] ex_idx;
    logic [31:0]      ex_addr;
    logic [31:0]      ex_data;
    logic [2:0]       ex_f3;

    logic             commit;
    logic             flush;
    logic [PTR_W-1:0] flush_tail;

    logic             ld_q_valid;
    logic [31:0]      ld_q_addr;
    logic [2:0]       ld_q_f3;
    logic [PTR_W-1:0] ld_q_sq_tail;
    logic             ld_fwd_hit;
    logic [31:0]      ld_fwd_data;
    logic             ld_stall;

    logic             mem_req_valid;
    logic [31:0]      mem_req_addr;
    logic [31:0]      mem_req_data;
    logic [3:0]       mem_req_strb;
    logic             mem_req_ready;
    logic             sq_empty;

    // Pipeline side driving the queue.
    modport master (
        output alloc_valid, alloc_rob_idx, ex_valid, ex_idx, ex_addr, ex_data, ex_f3,
               commit, flush, flush_tail, ld_q_valid, ld_q_addr, ld_q_f3, ld_q_sq_tail,
               mem_req_ready,
        input  alloc_ready, sq_tail, ld_fwd_hit, ld_fwd_data, ld_stall,
               mem_req_valid, mem_req_addr, mem_req_data, mem_req_strb, sq_empty
    );

    // The store queue itself.
    modport slave (
        input  alloc_valid, alloc_rob_idx, ex_valid, ex_idx, ex_addr, ex_data, ex_f3,
               commit, flush, flush_tail, ld_q_valid, ld_q_addr, ld_q_f3, ld_q_sq_tail,
               mem_req_ready,
        output alloc_ready, sq_tail, ld_fwd_hit, ld_fwd_data, ld_stall,
               mem_req_valid, mem_req_addr, mem_req_data, mem_req_strb, sq_empty
    );
endinterface

// File: rtl/lsu_sq_fwd.sv
// Store queue with byte-accurate store-to-load forwarding and in-order drain of
// committed stores. Pointers carry a phase bit so full/empty and age ranges are
// unambiguous when head and tail share an index.
module lsu_sq_fwd #(
    parameter int SQ_DEPTH = 8,
    parameter int ROB_W    = 5
) (
    input logic         clk,
    input logic         rst,
    lsu_sq_fwd_if.slave bus
);
    localparam int PTR_W = $clog2(SQ_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    typedef struct packed {
        logic             valid;
        logic             executed;
        logic             committed;
        logic [ROB_W-1:0] rob_idx;
        logic [29:0]      waddr;
        logic [3:0]       mask;
        logic [31:0]      data;
    } sq_ent_t;

    sq_ent_t          sq [SQ_DEPTH];
    logic [PTR_W-1:0] head, tail, cmt;

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: byte_mask = 4'b0001 << a;
            3'b001, 3'b101: byte_mask = 4'b0011 << a;
            default:        byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    wire [IDX_W-1:0] head_idx = head[IDX_W-1:0];
    wire [IDX_W-1:0] tail_idx = tail[IDX_W-1:0];
    wire [IDX_W-1:0] cmt_idx  = cmt[IDX_W-1:0];
    wire [IDX_W-1:0] ex_sidx  = bus.ex_idx[IDX_W-1:0];

    wire full       = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    wire alloc_fire = bus.alloc_valid && !full && !bus.flush;
    wire drain_fire = bus.mem_req_valid && bus.mem_req_ready;

    wire [3:0]  ex_mask = byte_mask(bus.ex_f3, bus.ex_addr[1:0]);
    wire [31:0] ex_lane = (bus.ex_data << {bus.ex_addr[1:0], 3'b000}) & lane_bits(ex_mask);

    assign bus.alloc_ready   = !full;
    assign bus.sq_tail       = tail;
    assign bus.sq_empty      = (head == tail);
    assign bus.mem_req_valid = sq[head_idx].valid && sq[head_idx].committed;
    assign bus.mem_req_addr  = {sq[head_idx].waddr, 2'b00};
    assign bus.mem_req_data  = sq[head_idx].data;
    assign bus.mem_req_strb  = sq[head_idx].mask;

    // Mark entries in [flush_tail, tail) for invalidation on a flush.
    logic [PTR_W-1:0]    fl_n;
    logic [IDX_W-1:0]    fl_i;
    logic [SQ_DEPTH-1:0] fl_kill;
    always_comb begin
        fl_kill = '0;
        fl_i    = '0;
        fl_n    = tail - bus.flush_tail;
        if (fl_n > PTR_W'(SQ_DEPTH)) fl_n = '0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            fl_i = bus.flush_tail[IDX_W-1:0] + IDX_W'(k);
            if (PTR_W'(k) < fl_n) fl_kill[fl_i] = 1'b1;
        end
    end

    // Pointer and entry state: drain, commit, execute, allocate, then flush kills last.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cmt  <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) sq[i] <= '0;
        end else begin
            if (drain_fire) begin
                sq[head_idx] <= '0;
                head         <= head + 1'b1;
            end
            if (bus.commit) begin
                sq[cmt_idx].committed <= 1'b1;
                cmt                   <= cmt + 1'b1;
            end
            if (bus.ex_valid) begin
                sq[ex_sidx].executed <= 1'b1;
                sq[ex_sidx].waddr    <= bus.ex_addr[31:2];
                sq[ex_sidx].mask     <= ex_mask;
                sq[ex_sidx].data     <= ex_lane;
            end
            if (bus.flush) begin
                tail <= bus.flush_tail;
                for (int i = 0; i < SQ_DEPTH; i++) begin
                    if (fl_kill[i] && !sq[i].committed) begin
                        sq[i].valid    <= 1'b0;
                        sq[i].executed <= 1'b0;
                    end
                end
            end else if (alloc_fire) begin
                sq[tail_idx]         <= '0;
                sq[tail_idx].valid   <= 1'b1;
                sq[tail_idx].rob_idx <= bus.alloc_rob_idx;
                tail                 <= tail + 1'b1;
            end
        end
    end

    // Forwarding search over [head, ld_q_sq_tail), oldest to youngest so the youngest match wins.
    logic [PTR_W-1:0] old_n;
    logic [IDX_W-1:0] q_i;
    logic [3:0]       ld_mask;
    logic             any_unexec, match;
    logic [3:0]       m_mask;
    logic [31:0]      m_data, m_sh, m_ext;
    always_comb begin
        any_unexec = 1'b0;
        match      = 1'b0;
        m_mask     = '0;
        m_data     = '0;
        q_i        = '0;
        ld_mask    = byte_mask(bus.ld_q_f3, bus.ld_q_addr[1:0]);
        old_n      = bus.ld_q_sq_tail - head;
        if (old_n > PTR_W'(SQ_DEPTH)) old_n = '0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            q_i = head_idx + IDX_W'(k);
            if (PTR_W'(k) < old_n && sq[q_i].valid) begin
                if (!sq[q_i].executed) begin
                    any_unexec = 1'b1;
                end else if (sq[q_i].waddr == bus.ld_q_addr[31:2] && |(sq[q_i].mask & ld_mask)) begin
                    match  = 1'b1;
                    m_mask = sq[q_i].mask;
                    m_data = sq[q_i].data;
                end
            end
        end
    end

    // Extract the load's lanes and extend per the load type.
    always_comb begin
        m_sh = m_data >> {bus.ld_q_addr[1:0], 3'b000};
        case (bus.ld_q_f3)
            3'b000:  m_ext = {{24{m_sh[7]}}, m_sh[7:0]};
            3'b001:  m_ext = {{16{m_sh[15]}}, m_sh[15:0]};
            3'b100:  m_ext = {24'b0, m_sh[7:0]};
            3'b101:  m_ext = {16'b0, m_sh[15:0]};
            default: m_ext = m_sh;
        endcase
    end

    wire covers = ((m_mask & ld_mask) == ld_mask);
    assign bus.ld_stall    = bus.ld_q_valid && (any_unexec || (match && !covers));
    assign bus.ld_fwd_hit  = bus.ld_q_valid && !any_unexec && match && covers;
    assign bus.ld_fwd_data = bus.ld_fwd_hit ? m_ext : 32'h0;
endmodule

// File: tb/tb_lsu_sq_fwd.sv
// Scoreboard bench for lsu_sq_fwd: load-query and drain expectations are queued
// when stimulus is applied and retired when the queue answers.
module tb_lsu_sq_fwd;
    localparam int SQ_DEPTH = 8;
    localparam int ROB_W    = 5;

    typedef struct { logic hit; logic stall; logic [31:0] data; } ld_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } mem_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    ld_exp_t  ld_q[$];
    mem_exp_t mem_q[$];

    lsu_sq_fwd_if #(.SQ_DEPTH(SQ_DEPTH), .ROB_W(ROB_W)) bus ();
    lsu_sq_fwd #(.SQ_DEPTH(SQ_DEPTH), .ROB_W(ROB_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [ROB_W-1:0] r);
        bus.alloc_valid = 1'b1; bus.alloc_rob_idx = r;
        step();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic exe(input logic [3:0] idx, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        bus.ex_valid = 1'b1; bus.ex_idx = idx; bus.ex_addr = a; bus.ex_data = d; bus.ex_f3 = f3;
        step();
        bus.ex_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_exp_t e;
        e.addr = a; e.data = d; e.strb = s;
        mem_q.push_back(e);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
    endtask

    // Apply a load query, queue its expectation, then retire it against the DUT.
    task automatic query(input string tag, input logic [31:0] a, input logic [2:0] f3, input logic [3:0] snap,
                         input logic eh, input logic es, input logic [31:0] ed);
        ld_exp_t e, p;
        e.hit = eh; e.stall = es; e.data = ed;
        ld_q.push_back(e);
        bus.ld_q_valid = 1'b1; bus.ld_q_addr = a; bus.ld_q_f3 = f3; bus.ld_q_sq_tail = snap;
        #2;
        p = ld_q.pop_front();
        chk({tag, ".hit"}, 32'(bus.ld_fwd_hit), 32'(p.hit));
        chk({tag, ".stall"}, 32'(bus.ld_stall), 32'(p.stall));
        chk({tag, ".data"}, bus.ld_fwd_data, p.data);
        bus.ld_q_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 50 && !bus.sq_empty; i++) step();
        chk({tag, ".empty"}, 32'(bus.sq_empty), 32'd1);
        chk({tag, ".left"}, mem_q.size(), 32'd0);
    endtask

    // Drain monitor: every presented request must match the oldest expected store,
    // and stay unchanged until it is accepted.
    always @(negedge clk) begin
        if (!rst && bus.mem_req_valid) begin
            if (mem_q.size() == 0) begin
                chk("spurious_req", 32'(bus.mem_req_valid), 32'd0);
            end else begin
                chk("req_addr", bus.mem_req_addr, mem_q[0].addr);
                chk("req_data", bus.mem_req_data, mem_q[0].data);
                chk("req_strb", 32'(bus.mem_req_strb), 32'(mem_q[0].strb));
                if (bus.mem_req_ready) void'(mem_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.alloc_valid = 0; bus.alloc_rob_idx = 0; bus.ex_valid = 0; bus.ex_idx = 0;
        bus.ex_addr = 0; bus.ex_data = 0; bus.ex_f3 = 0; bus.commit = 0; bus.flush = 0;
        bus.flush_tail = 0; bus.ld_q_valid = 0; bus.ld_q_addr = 0; bus.ld_q_f3 = 0;
        bus.ld_q_sq_tail = 0; bus.mem_req_ready = 0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst.alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("rst.empty", 32'(bus.sq_empty), 32'd1);
        chk("rst.req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst.tail", 32'(bus.sq_tail), 32'd0);
        chk("rst.fwd", {bus.ld_fwd_data[29:0], bus.ld_fwd_hit, bus.ld_stall}, 32'd0);

        // Fill to full, then one ignored alloc.
        for (int i = 0; i < SQ_DEPTH; i++) begin
            chk("fill.ready", 32'(bus.alloc_ready), 32'd1);
            alloc(ROB_W'(i));
        end
        chk("full.ready", 32'(bus.alloc_ready), 32'd0);
        chk("full.tail", 32'(bus.sq_tail), 32'b1000);
        alloc(5'd9);
        chk("full.ign_tail", 32'(bus.sq_tail), 32'b1000);
        // Flush everything back to empty.
        bus.flush = 1'b1; bus.flush_tail = 4'd0;
        step();
        bus.flush = 1'b0;
        chk("flushall.empty", 32'(bus.sq_empty), 32'd1);
        chk("flushall.ready", 32'(bus.alloc_ready), 32'd1);

        // SW forwarding with lane extraction and extension.
        alloc(5'd1);
        exe(4'd0, 32'h100, 32'hDEADBEEF, 3'b010);
        query("lw100", 32'h100, 3'b010, 4'd1, 1'b1, 1'b0, 32'hDEADBEEF);
        query("lbu103", 32'h103, 3'b100, 4'd1, 1'b1, 1'b0, 32'h000000DE);
        query("lb103", 32'h103, 3'b000, 4'd1, 1'b1, 1'b0, 32'hFFFFFFDE);
        query("lw100_older", 32'h100, 3'b010, 4'd0, 1'b0, 1'b0, 32'h0);

        // Younger unexecuted store stalls; once executed it supplies the data.
        alloc(5'd2);
        alloc(5'd3);
        exe(4'd1, 32'h200, 32'h00000055, 3'b000);
        query("lw200_stall", 32'h200, 3'b010, 4'd3, 1'b0, 1'b1, 32'h0);
        exe(4'd2, 32'h200, 32'h11223344, 3'b010);
        query("lw200_hit", 32'h200, 3'b010, 4'd3, 1'b1, 1'b0, 32'h11223344);
        query("lbu200_sb", 32'h200, 3'b100, 4'd2, 1'b1, 1'b0, 32'h00000055);

        // Partial overlap and address miss.
        alloc(5'd4);
        exe(4'd3, 32'h300, 32'h0000007F, 3'b000);
        query("lw300_part", 32'h300, 3'b010, 4'd4, 1'b0, 1'b1, 32'h0);
        query("lw304_miss", 32'h304, 3'b010, 4'd4, 1'b0, 1'b0, 32'h0);
        query("lbu300", 32'h300, 3'b100, 4'd4, 1'b1, 1'b0, 32'h0000007F);

        // Drain all four with memory always ready.
        bus.mem_req_ready = 1'b1;
        do_commit(32'h100, 32'hDEADBEEF, 4'hF);
        do_commit(32'h200, 32'h00000055, 4'h1);
        do_commit(32'h200, 32'h11223344, 4'hF);
        do_commit(32'h300, 32'h0000007F, 4'h1);
        wait_empty("drain4");

        // Backpressure: SH lane placement, request held stable while not ready.
        alloc(5'd5);
        alloc(5'd6);
        exe(4'd4, 32'h402, 32'h0000BEEF, 3'b001);
        exe(4'd5, 32'h500, 32'hCAFEF00D, 3'b010);
        query("lhu402", 32'h402, 3'b101, 4'd6, 1'b1, 1'b0, 32'h0000BEEF);
        query("lh402", 32'h402, 3'b001, 4'd6, 1'b1, 1'b0, 32'hFFFFBEEF);
        bus.mem_req_ready = 1'b0;
        do_commit(32'h400, 32'hBEEF0000, 4'b1100);
        do_commit(32'h500, 32'hCAFEF00D, 4'hF);
        chk("bp.valid", 32'(bus.mem_req_valid), 32'd1);
        step(); step(); step();
        chk("bp.held", mem_q.size(), 32'd2);
        bus.mem_req_ready = 1'b1;
        wait_empty("bp");

        // Reset while a request is waiting drops it immediately.
        alloc(5'd7);
        exe(4'd6, 32'h700, 32'h00000001, 3'b010);
        bus.mem_req_ready = 1'b0;
        do_commit(32'h700, 32'h00000001, 4'hF);
        chk("rstd.valid_before", 32'(bus.mem_req_valid), 32'd1);
        rst = 1'b1;
        mem_q.delete();
        step();
        chk("rstd.valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rstd.empty", 32'(bus.sq_empty), 32'd1);
        chk("rstd.tail", 32'(bus.sq_tail), 32'd0);
        rst = 1'b0;

        // Flush with a concurrent alloc: committed entry 0 survives, 1..3 die.
        for (int i = 0; i < 4; i++) alloc(ROB_W'(10 + i));
        exe(4'd0, 32'h600, 32'h600D600D, 3'b010);
        exe(4'd1, 32'h600, 32'hBAD0BAD0, 3'b010);
        do_commit(32'h600, 32'h600D600D, 4'hF);
        bus.flush = 1'b1; bus.flush_tail = 4'd1;
        bus.alloc_valid = 1'b1; bus.alloc_rob_idx = 5'd20;
        step();
        bus.flush = 1'b0; bus.alloc_valid = 1'b0;
        chk("fl.tail", 32'(bus.sq_tail), 32'd1);
        chk("fl.empty", 32'(bus.sq_empty), 32'd0);
        query("fl.lw600", 32'h600, 3'b010, 4'd4, 1'b1, 1'b0, 32'h600D600D);
        bus.mem_req_ready = 1'b1;
        wait_empty("fl");
        chk("fl.tail_after", 32'(bus.sq_tail), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
